sync_fifo_param: RTL and testbench

- Parametrised single-clock FIFO; next generation of the team's 4-bit/8-deep synchronous FIFO.
- Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags with a clear input.
- Used as the generic buffering element between producer and consumer blocks in one clock domain.

---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/fifo_mem_2p.sv | 25 ++
 rtl/sync_fifo_param.sv | 103 ++++++++++
 tb/tb_sync_fifo_param.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: address-width and
// parameter-legality functions evaluated at elaboration time.
package sync_fifo_pkg;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit fifo_params_ok(input int data_w, input int depth,
                                          input int af_level, input int ae_level);
        return (data_w >= 1) && is_pow2(depth) && (depth >= 4) &&
               (ae_level > 0) && (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DATA_W x DEPTH register array: synchronous write port, combinational read port.
module fifo_mem_2p
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        i_we,
    input  logic [clog2_f(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [clog2_f(DEPTH)-1:0]   i_raddr,
    output logic [DATA_W-1:0]           o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage is deliberately left unreset; flags guard against stale reads.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and
// sticky error flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        w_en,
    input  logic                        r_en,
    input  logic [DATA_W-1:0]           data_in,
    output logic [DATA_W-1:0]           data_out,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [clog2_f(DEPTH):0]     count,
    input  logic                        err_clr,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int AW = clog2_f(DEPTH);
    localparam int PW = AW + 1;

    if (!fifo_params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_count;
    logic               r_ovf;
    logic               r_udf;
    logic               w_wr_ok;
    logic               w_rd_ok;
    logic               w_full;
    logic               w_empty;
    logic [DATA_W-1:0]  w_rdata;

    // Flags decode straight from the registered count, so they move with it.
    assign w_full  = (r_count == PW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A write while full is accepted only if a read frees a slot in the same cycle.
    assign w_wr_ok = w_en & (~w_full | r_en);
    assign w_rd_ok = r_en & ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + PW'(w_wr_ok) - PW'(w_rd_ok);
            // A fresh error event outranks a simultaneous clear.
            r_ovf   <= (w_en & w_full & ~r_en) | (r_ovf & ~err_clr);
            r_udf   <= (r_en & w_empty) | (r_udf & ~err_clr);
        end
    end

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = w_rdata;
`else
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_dout <= '0;
        else if (w_rd_ok) r_dout <= w_rdata;
    end

    assign data_out = r_dout;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= PW'(AF_LEVEL));
    assign almost_empty = (r_count <= PW'(AE_LEVEL));
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DATA_W=4, DEPTH=8); a queue model
// tracks contents, flags and sticky errors. Honours SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;

    localparam int DW  = 4;
    localparam int DEP = 8;
    localparam int AF  = 6;
    localparam int AE  = 2;

    logic          clk;
    logic          rst_n;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          err_clr;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [DW-1:0] m_q[$];
    logic          m_ovf;
    logic          m_udf;
    logic [DW-1:0] m_dout;

    sync_fifo_param #(
        .DATA_W   (DW),
        .DEPTH    (DEP),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_en         (w_en),
        .r_en         (r_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) assert (count <= 4'(DEP)) else $error("count above DEPTH: %0d", count);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = '0;
    endtask

    task automatic model_edge(input logic w, input logic r, input logic [DW-1:0] d,
                              input logic clr);
        bit m_full, m_empty;
        logic [DW-1:0] popped;
        m_full  = (m_q.size() == DEP);
        m_empty = (m_q.size() == 0);
        m_ovf   = (w && m_full && !r) || (m_ovf && !clr);
        m_udf   = (r && m_empty) || (m_udf && !clr);
        if (r && !m_empty) begin
            popped = m_q.pop_front();
            m_dout = popped;
        end
        if (w && (!m_full || r)) m_q.push_back(d);
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        chk("count",        32'(count),        32'(n));
        chk("count_range",  32'(count <= 4'(DEP)), 32'd1);
        chk("empty",        32'(empty),        32'(n == 0));
        chk("full",         32'(full),         32'(n == DEP));
        chk("almost_full",  32'(almost_full),  32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        if (n != 0) chk("data_out", 32'(data_out), 32'(m_q[0]));
`else
        chk("data_out", 32'(data_out), 32'(m_dout));
`endif
    endtask

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d,
                        input logic clr);
        w_en    = w;
        r_en    = r;
        data_in = d;
        err_clr = clr;
        @(posedge clk);
        model_edge(w, r, d, clr);
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
    endtask

    initial begin
        rst_n   = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        err_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // Fill and drain
        for (int i = 0; i < DEP; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
        for (int i = 0; i < DEP; i++) step(1'b0, 1'b1, '0, 1'b0);

        // Overflow, drain, clear
        for (int i = 0; i < DEP; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
        step(1'b1, 1'b0, 4'hA, 1'b0);
        for (int i = 0; i < DEP; i++) step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Underflow with simultaneous write, then clear racing a new error
        step(1'b1, 1'b1, 4'h5, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Read+write while full, then steady-state wrap at count 4
        for (int i = 0; i < DEP; i++) step(1'b1, 1'b0, DW'(i + 3), 1'b0);
        step(1'b1, 1'b1, 4'hC, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'($urandom_range(0, 15)), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, 1'b0);

        // Mid-operation reset, then first-word visibility
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(i + 1), 1'b0);
        pulse_reset();
        step(1'b1, 1'b0, 4'h9, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);

        // Randomised traffic with drifting read/write bias
        for (int i = 0; i < 600; i++) begin
            int wp, rp;
            wp = ((i / 100) % 2 == 0) ? 75 : 35;
            rp = 110 - wp;
            step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
                 DW'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
            if (i == 300) pulse_reset();
        end

        w_en    = 1'b0;
        r_en    = 1'b0;
        err_clr = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
